// File: rtl/lc3b_types.sv
// -----------------------------------------------------------------------------
// lc3b_types
// Shared LC-3b types for the decode stage: instruction word, opcode and ALU
// operation enums, mux-select constants, decode FSM state, indirect phase
// selector and the lc3b_control word carried down the pipeline.
// -----------------------------------------------------------------------------
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    typedef enum logic [3:0] {
        op_br   = 4'h0,
        op_add  = 4'h1,
        op_ldb  = 4'h2,
        op_stb  = 4'h3,
        op_jsr  = 4'h4,
        op_and  = 4'h5,
        op_ldr  = 4'h6,
        op_str  = 4'h7,
        op_rti  = 4'h8,
        op_not  = 4'h9,
        op_ldi  = 4'hA,
        op_sti  = 4'hB,
        op_jmp  = 4'hC,
        op_shf  = 4'hD,
        op_lea  = 4'hE,
        op_trap = 4'hF
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } lc3b_aluop;

    // PC mux selects
    localparam logic [1:0] PC_PLUS2  = 2'd0;
    localparam logic [1:0] PC_OFFSET = 2'd1;
    localparam logic [1:0] PC_SR1    = 2'd2;
    localparam logic [1:0] PC_MEM    = 2'd3;

    // Write-back mux selects
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_PC   = 2'd2;
    localparam logic [1:0] WB_ADDR = 2'd3;

    // Offset mux selects
    localparam logic [1:0] OFF6  = 2'd0;
    localparam logic [1:0] OFF9  = 2'd1;
    localparam logic [1:0] OFF11 = 2'd2;

    typedef enum logic {
        IDLE = 1'b0,
        IND2 = 1'b1
    } lc3b_decode_state;

    // Which control word the ROM produces for LDI/STI; ignored otherwise.
    typedef enum logic [1:0] {
        PH_NORMAL = 2'd0,
        PH_IND1   = 2'd1,
        PH_IND2   = 2'd2
    } lc3b_phase;

    typedef struct packed {
        lc3b_opcode opcode;
        lc3b_aluop  aluop;
        logic       load_regfile;
        logic       load_cc;
        logic       load_pc;
        logic       read_memory;
        logic       write_memory;
        logic       immsr2_mux_sel;
        logic       dest_mux_sel;
        logic       address_mux_sel;
        logic       instrsr1_mux_sel;
        logic [1:0] pc_mux_sel;
        logic [1:0] offset_mux_sel;
        logic [1:0] wb_mux_sel;
        lc3b_word   ir;
    } lc3b_control;

    // All-zero word: opcode decodes as op_br, aluop as alu_add.
    localparam lc3b_control CTRL_RESET = '0;

    function automatic logic is_indirect(input lc3b_word ir);
        return (ir[15:12] == op_ldi) || (ir[15:12] == op_sti);
    endfunction

endpackage

// File: rtl/lc3b_decode_stage_if.sv
// -----------------------------------------------------------------------------
// lc3b_decode_stage_if
// Fetch-side and execute-side signals of the decode stage.
//   if_valid/if_ir/if_pc/if_ready : fetch -> decode handshake
//   flush                         : drop held work
//   ex_ready                      : execute consumes ex_ctrl
//   ex_valid/ex_ctrl/ex_pc/ex_indirect : ID/EX register contents
// Modports: slave = decode stage, master = surrounding pipeline.
// -----------------------------------------------------------------------------
interface lc3b_decode_stage_if;
    import lc3b_types::*;

    logic        if_valid;
    lc3b_word    if_ir;
    lc3b_word    if_pc;
    logic        if_ready;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    lc3b_control ex_ctrl;
    lc3b_word    ex_pc;
    logic        ex_indirect;

    modport slave (
        input  if_valid, if_ir, if_pc, flush, ex_ready,
        output if_ready, ex_valid, ex_ctrl, ex_pc, ex_indirect
    );

    modport master (
        output if_valid, if_ir, if_pc, flush, ex_ready,
        input  if_ready, ex_valid, ex_ctrl, ex_pc, ex_indirect
    );

endinterface

// File: rtl/lc3b_control_rom.sv
// -----------------------------------------------------------------------------
// lc3b_control_rom
// Purely combinational decode of an instruction word into lc3b_control.
//   i_ir    : instruction word
//   i_phase : PH_NORMAL, PH_IND1 or PH_IND2 (only LDI/STI look at it)
//   o_ctrl  : control word; opcode and ir always carry the instruction
// -----------------------------------------------------------------------------
module lc3b_control_rom
    import lc3b_types::*;
(
    input  lc3b_word    i_ir,
    input  lc3b_phase   i_phase,
    output lc3b_control o_ctrl
);

    always_comb begin
        // NOTE: o_ctrl gets a full default before the case, so every path
        // assigns every field and no latch can be inferred.
        o_ctrl        = CTRL_RESET;
        o_ctrl.opcode = lc3b_opcode'(i_ir[15:12]);
        o_ctrl.ir     = i_ir;

        case (o_ctrl.opcode)
            op_add, op_and, op_not: begin
                o_ctrl.aluop          = (o_ctrl.opcode == op_add) ? alu_add :
                                        (o_ctrl.opcode == op_and) ? alu_and : alu_not;
                o_ctrl.load_regfile   = 1'b1;
                o_ctrl.load_cc        = 1'b1;
                o_ctrl.immsr2_mux_sel = (o_ctrl.opcode == op_not) ? 1'b0 : i_ir[5];
            end
            op_shf: begin
                // ir[5] set selects arithmetic right shift for both 10 and 11.
                o_ctrl.aluop        = i_ir[5] ? alu_sra : (i_ir[4] ? alu_srl : alu_sll);
                o_ctrl.load_regfile = 1'b1;
                o_ctrl.load_cc      = 1'b1;
            end
            op_br: begin
                o_ctrl.load_pc        = 1'b1;
                o_ctrl.pc_mux_sel     = PC_OFFSET;
                o_ctrl.offset_mux_sel = OFF9;
            end
            op_jmp: begin
                o_ctrl.load_pc    = 1'b1;
                o_ctrl.pc_mux_sel = PC_SR1;
            end
            op_jsr: begin
                o_ctrl.load_pc      = 1'b1;
                o_ctrl.load_regfile = 1'b1;
                o_ctrl.dest_mux_sel = 1'b1;
                o_ctrl.wb_mux_sel   = WB_PC;
                if (i_ir[11]) begin
                    o_ctrl.pc_mux_sel     = PC_OFFSET;
                    o_ctrl.offset_mux_sel = OFF11;
                end else begin
                    o_ctrl.pc_mux_sel = PC_SR1;
                end
            end
            op_ldr, op_ldb: begin
                o_ctrl.read_memory    = 1'b1;
                o_ctrl.load_regfile   = 1'b1;
                o_ctrl.load_cc        = 1'b1;
                o_ctrl.wb_mux_sel     = WB_MEM;
                o_ctrl.offset_mux_sel = OFF6;
            end
            op_str, op_stb: begin
                o_ctrl.write_memory     = 1'b1;
                o_ctrl.offset_mux_sel   = OFF6;
                o_ctrl.instrsr1_mux_sel = 1'b1;
            end
            op_lea: begin
                o_ctrl.load_regfile   = 1'b1;
                o_ctrl.load_cc        = 1'b1;
                o_ctrl.wb_mux_sel     = WB_ADDR;
                o_ctrl.offset_mux_sel = OFF9;
            end
            op_trap: begin
                o_ctrl.read_memory     = 1'b1;
                o_ctrl.address_mux_sel = 1'b1;
                o_ctrl.load_pc         = 1'b1;
                o_ctrl.pc_mux_sel      = PC_MEM;
                o_ctrl.load_regfile    = 1'b1;
                o_ctrl.dest_mux_sel    = 1'b1;
                o_ctrl.wb_mux_sel      = WB_PC;
            end
            op_ldi, op_sti: begin
                if (i_phase == PH_IND2) begin
                    // Address comes from the phase-1 read data, not trapvect.
                    o_ctrl.address_mux_sel = 1'b0;
                    if (o_ctrl.opcode == op_ldi) begin
                        o_ctrl.read_memory  = 1'b1;
                        o_ctrl.load_regfile = 1'b1;
                        o_ctrl.load_cc      = 1'b1;
                        o_ctrl.wb_mux_sel   = WB_MEM;
                    end else begin
                        o_ctrl.write_memory     = 1'b1;
                        o_ctrl.instrsr1_mux_sel = 1'b1;
                    end
                end else begin
                    // Phase 1: fetch the pointer only, no architectural write.
                    o_ctrl.read_memory    = 1'b1;
                    o_ctrl.offset_mux_sel = OFF6;
                    o_ctrl.wb_mux_sel     = WB_MEM;
                end
            end
            default: begin
                // RTI is not supported here and executes as a NOP.
                o_ctrl.aluop = alu_pass;
            end
        endcase
    end

endmodule

// File: rtl/lc3b_decode_stage.sv
// -----------------------------------------------------------------------------
// lc3b_decode_stage
// Decode stage between fetch and execute. Accepts an instruction over a
// valid/ready handshake, decodes it through lc3b_control_rom and holds the
// result in the ID/EX register. LDI/STI are issued as two control words.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : lc3b_decode_stage_if.slave (fetch handshake, flush, ID/EX outputs)
// -----------------------------------------------------------------------------
module lc3b_decode_stage
    import lc3b_types::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    lc3b_decode_stage_if.slave    bus
);

    lc3b_decode_state r_state;
    lc3b_decode_state w_state_next;

    logic        r_ex_valid;
    logic        r_ex_indirect;
    lc3b_control r_ex_ctrl;
    lc3b_word    r_ex_pc;

    logic        w_if_ready;
    logic        w_if_fire;
    logic        w_is_ind;
    logic        w_load_new;
    logic        w_load_ph2;
    logic        w_drain;
    lc3b_word    w_rom_ir;
    lc3b_phase   w_rom_phase;
    lc3b_control w_rom_ctrl;

    assign w_is_ind  = is_indirect(bus.if_ir);
    assign w_if_fire = bus.if_valid & w_if_ready;

    // ------------------------------------------------------------ state register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        w_state_next = r_state;
        if (bus.flush) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_if_fire && w_is_ind) w_state_next = IND2;
                IND2:    if (bus.ex_ready)          w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------ FSM outputs
    always_comb begin
        w_if_ready  = rst_n && (r_state == IDLE) && (!r_ex_valid || bus.ex_ready) && !bus.flush;
        w_load_new  = 1'b0;
        w_load_ph2  = 1'b0;
        w_drain     = 1'b0;
        w_rom_ir    = bus.if_ir;
        w_rom_phase = w_is_ind ? PH_IND1 : PH_NORMAL;
        case (r_state)
            IDLE: begin
                w_load_new = w_if_fire;
                w_drain    = !w_if_fire && bus.ex_ready;
            end
            IND2: begin
                // Phase 2 re-decodes the instruction already held in ID/EX.
                w_rom_ir    = r_ex_ctrl.ir;
                w_rom_phase = PH_IND2;
                w_load_ph2  = bus.ex_ready;
            end
            default: ;
        endcase
    end

    lc3b_control_rom u_rom (
        .i_ir    (w_rom_ir),
        .i_phase (w_rom_phase),
        .o_ctrl  (w_rom_ctrl)
    );

    // ------------------------------------------------------------ ID/EX register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_valid    <= 1'b0;
            r_ex_indirect <= 1'b0;
            r_ex_ctrl     <= CTRL_RESET;
            r_ex_pc       <= '0;
        end else if (bus.flush) begin
            r_ex_valid    <= 1'b0;
            r_ex_indirect <= 1'b0;
        end else if (w_load_new) begin
            r_ex_valid    <= 1'b1;
            r_ex_indirect <= 1'b0;
            r_ex_ctrl     <= w_rom_ctrl;
            r_ex_pc       <= bus.if_pc;
        end else if (w_load_ph2) begin
            r_ex_indirect <= 1'b1;
            r_ex_ctrl     <= w_rom_ctrl;
        end else if (w_drain) begin
            r_ex_valid    <= 1'b0;
            r_ex_indirect <= 1'b0;
        end
    end

    assign bus.if_ready    = w_if_ready;
    assign bus.ex_valid    = r_ex_valid;
    assign bus.ex_indirect = r_ex_indirect;
    assign bus.ex_ctrl     = r_ex_ctrl;
    assign bus.ex_pc       = r_ex_pc;

endmodule

// File: tb/tb_lc3b_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_lc3b_decode_stage
// Self-checking bench for lc3b_decode_stage: directed scenarios followed by
// random traffic, checked every cycle against a queue of expected ID/EX words.
// -----------------------------------------------------------------------------
module tb_lc3b_decode_stage;
    import lc3b_types::*;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    lc3b_decode_stage_if bus ();

    lc3b_decode_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        lc3b_control ctrl;
        logic [15:0] pc;
        logic        ind;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        prev_hold = 1'b0;
    lc3b_control prev_ctrl;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected control word derived from the instruction semantics.
    function automatic lc3b_control ref_word(input logic [15:0] ir, input int phase);
        lc3b_control c = '0;
        c.opcode = lc3b_opcode'(ir[15:12]);
        c.ir     = ir;
        case (ir[15:12])
            4'h1: begin c.aluop = alu_add; c.load_regfile = 1; c.load_cc = 1; c.immsr2_mux_sel = ir[5]; end
            4'h5: begin c.aluop = alu_and; c.load_regfile = 1; c.load_cc = 1; c.immsr2_mux_sel = ir[5]; end
            4'h9: begin c.aluop = alu_not; c.load_regfile = 1; c.load_cc = 1; end
            4'hD: begin
                if (ir[5])      c.aluop = alu_sra;
                else if (ir[4]) c.aluop = alu_srl;
                else            c.aluop = alu_sll;
                c.load_regfile = 1; c.load_cc = 1;
            end
            4'h0: begin c.load_pc = 1; c.pc_mux_sel = 2'd1; c.offset_mux_sel = 2'd1; end
            4'hC: begin c.load_pc = 1; c.pc_mux_sel = 2'd2; end
            4'h4: begin
                c.load_pc = 1; c.load_regfile = 1; c.dest_mux_sel = 1; c.wb_mux_sel = 2'd2;
                if (ir[11]) begin c.pc_mux_sel = 2'd1; c.offset_mux_sel = 2'd2; end
                else        c.pc_mux_sel = 2'd2;
            end
            4'h2, 4'h6: begin c.read_memory = 1; c.load_regfile = 1; c.load_cc = 1; c.wb_mux_sel = 2'd1; end
            4'h3, 4'h7: begin c.write_memory = 1; c.instrsr1_mux_sel = 1; end
            4'hE: begin c.load_regfile = 1; c.load_cc = 1; c.wb_mux_sel = 2'd3; c.offset_mux_sel = 2'd1; end
            4'hF: begin
                c.read_memory = 1; c.address_mux_sel = 1; c.load_pc = 1; c.pc_mux_sel = 2'd3;
                c.load_regfile = 1; c.dest_mux_sel = 1; c.wb_mux_sel = 2'd2;
            end
            4'hA: begin
                c.read_memory = 1;
                c.wb_mux_sel  = 2'd1;
                if (phase == 2) begin c.load_regfile = 1; c.load_cc = 1; end
            end
            4'hB: begin
                if (phase == 2) begin c.write_memory = 1; c.instrsr1_mux_sel = 1; end
                else begin c.read_memory = 1; c.wb_mux_sel = 2'd1; end
            end
            default: c.aluop = alu_pass;
        endcase
        return c;
    endfunction

    // One clock: check outputs at the falling edge, advance the model for the
    // coming rising edge, then return 1 time unit after that edge.
    task automatic cycle();
        logic exp_ready;
        exp_t e;
        @(negedge clk);
        exp_ready = rst_n && !bus.flush && (q.size() == 0 || (q.size() == 1 && bus.ex_ready));
        check("if_ready", bus.if_ready, exp_ready);
        check("ex_valid", bus.ex_valid, q.size() > 0);
        if (q.size() > 0) begin
            check("ex_ctrl", bus.ex_ctrl, q[0].ctrl);
            check("ex_pc", bus.ex_pc, q[0].pc);
            check("ex_indirect", bus.ex_indirect, q[0].ind);
        end
        if (prev_hold) check("hold_stable", bus.ex_ctrl, prev_ctrl);
        prev_hold = rst_n && !bus.flush && (q.size() > 0) && !bus.ex_ready;
        prev_ctrl = bus.ex_ctrl;

        if (!rst_n || bus.flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && bus.ex_ready) void'(q.pop_front());
            if (bus.if_valid && exp_ready) begin
                e.pc = bus.if_pc;
                if (bus.if_ir[15:12] == 4'hA || bus.if_ir[15:12] == 4'hB) begin
                    e.ctrl = ref_word(bus.if_ir, 1); e.ind = 1'b0; q.push_back(e);
                    e.ctrl = ref_word(bus.if_ir, 2); e.ind = 1'b1; q.push_back(e);
                end else begin
                    e.ctrl = ref_word(bus.if_ir, 0); e.ind = 1'b0; q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ir, input logic er, input logic fl);
        bus.if_valid = v;
        bus.if_ir    = ir;
        bus.if_pc    = $urandom();
        bus.ex_ready = er;
        bus.flush    = fl;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 16'h0000, 0, 0);
        cycle();
        cycle();
        check("rst_ctrl", bus.ex_ctrl, CTRL_RESET);
        check("rst_pc", bus.ex_pc, 16'h0);
        check("rst_ind", bus.ex_indirect, 1'b0);
        check("rst_if_ready", bus.if_ready, 1'b0);
        rst_n = 1'b1;
        cycle();

        // ADD R1=R2+R3
        drive(1, 16'h1283, 1, 0);
        cycle();
        drive(0, 16'h0000, 0, 0);
        check("add_valid", bus.ex_valid, 1'b1);
        check("add_aluop", bus.ex_ctrl.aluop, alu_add);
        check("add_ldreg", bus.ex_ctrl.load_regfile, 1'b1);
        check("add_ldcc", bus.ex_ctrl.load_cc, 1'b1);
        check("add_imm", bus.ex_ctrl.immsr2_mux_sel, 1'b0);
        bus.ex_ready = 1;
        cycle();

        // Three ANDs with two back-pressure cycles
        drive(1, 16'h5262, 1, 0);
        cycle();
        drive(1, 16'h5A3F, 0, 0);
        cycle();
        check("and_hold_ready", bus.if_ready, 1'b0);
        cycle();
        bus.ex_ready = 1;
        cycle();
        drive(1, 16'h5E01, 1, 0);
        cycle();
        drive(0, 16'h0000, 1, 0);
        check("and3_ir", bus.ex_ctrl.ir, 16'h5E01);
        cycle();

        // LDI: two control words, fetch stalled in between
        drive(1, 16'hA245, 1, 0);
        cycle();
        drive(0, 16'h0000, 1, 0);
        check("ldi1_rd", bus.ex_ctrl.read_memory, 1'b1);
        check("ldi1_ldreg", bus.ex_ctrl.load_regfile, 1'b0);
        check("ldi1_ind", bus.ex_indirect, 1'b0);
        check("ldi_if_ready", bus.if_ready, 1'b0);
        cycle();
        check("ldi2_ind", bus.ex_indirect, 1'b1);
        check("ldi2_ldreg", bus.ex_ctrl.load_regfile, 1'b1);
        cycle();

        // STI flushed in IND2, then an ADD is accepted
        drive(1, 16'hB245, 1, 0);
        cycle();
        drive(0, 16'h0000, 0, 1);
        cycle();
        check("sti_fl_valid", bus.ex_valid, 1'b0);
        check("sti_fl_ind", bus.ex_indirect, 1'b0);
        drive(1, 16'h1283, 1, 0);
        cycle();
        drive(0, 16'h0000, 1, 0);
        check("post_flush_op", bus.ex_ctrl.opcode, op_add);
        check("post_flush_wr", bus.ex_ctrl.write_memory, 1'b0);
        cycle();

        // Reset during back-pressured JSR
        drive(1, 16'h4802, 1, 0);
        cycle();
        drive(0, 16'h0000, 0, 0);
        cycle();
        rst_n = 1'b0;
        cycle();
        check("jsr_rst_valid", bus.ex_valid, 1'b0);
        check("jsr_rst_ctrl", bus.ex_ctrl, CTRL_RESET);
        check("jsr_rst_pc", bus.ex_pc, 16'h0);
        rst_n = 1'b1;
        cycle();
        check("jsr_rel_ready", bus.if_ready, 1'b1);

        // TRAP then RTI
        drive(1, 16'hF025, 1, 0);
        cycle();
        check("trap_pcsel", bus.ex_ctrl.pc_mux_sel, 2'd3);
        check("trap_dest", bus.ex_ctrl.dest_mux_sel, 1'b1);
        check("trap_rd", bus.ex_ctrl.read_memory, 1'b1);
        drive(1, 16'h8000, 1, 0);
        cycle();
        drive(0, 16'h0000, 1, 0);
        check("rti_loads", {bus.ex_ctrl.load_regfile, bus.ex_ctrl.load_cc, bus.ex_ctrl.load_pc,
                            bus.ex_ctrl.read_memory, bus.ex_ctrl.write_memory}, 5'b0);
        check("rti_alu", bus.ex_ctrl.aluop, alu_pass);
        cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 99) < 70, 16'($urandom()),
                  $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 4);
            rst_n = ($urandom_range(0, 99) != 0);
            cycle();
        end
        rst_n = 1'b1;
        drive(0, 16'h0000, 1, 0);
        repeat (4) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lc3b_decode_stage.md
# lc3b_decode_stage

Decode stage of the LC-3b pipeline, between fetch and execute. Accepts a fetched instruction word and PC over a valid/ready handshake, expands it into an `lc3b_control` word, and holds the result in the ID/EX pipeline register. LDI and STI are split into two sequential control words, so downstream stages see only single-memory-access operations.

## Interface
- No parameters. Widths come from `lc3b_types`.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `if_valid` in 1: fetch is presenting an instruction.
- `if_ir` in 16: instruction word (`lc3b_word`).
- `if_pc` in 16: PC+2 of that instruction.
- `if_ready` out 1: decode accepts this cycle (combinational).
- `flush` in 1: discard the held instruction and any pending indirect phase.
- `ex_ready` in 1: execute consumes `ex_ctrl` this cycle.
- `ex_valid` out 1: `ex_ctrl`/`ex_pc` hold a live operation.
- `ex_ctrl` out `lc3b_control`: decoded control word.
- `ex_pc` out 16: PC of the held instruction.
- `ex_indirect` out 1: high when `ex_ctrl` is the second phase of LDI/STI.

## Operation
- State machine: IDLE, IND2.
- Accept: `if_fire = if_valid & if_ready`.
  - `if_ready = (state==IDLE) & (!ex_valid | ex_ready) & !flush`.
- IDLE with `if_fire`:
  - Load `decode(if_ir)`, `if_pc`, and set `ex_valid=1`.
  - Opcode LDI or STI: load phase-1 word instead, then go to IND2.
- IDLE, no `if_fire`, `ex_ready` high: clear `ex_valid`.
- IND2 with `ex_ready`:
  - Load phase-2 word with the same `ir`/`pc`.
  - Set `ex_indirect=1` and return to IDLE.
  - In IND2, `if_ready` is 0.
- `ex_valid=0` with `ex_ready` high is a no-op for execute.
- Decode, by opcode (every unlisted field is 0):
  - ADD/AND/NOT: `aluop` per opcode; `load_regfile=1`, `load_cc=1`. `immsr2_mux_sel=ir[5]` for ADD/AND.
  - SHF: `aluop` from `ir[5:4]`: 00 `alu_sll`, 01 `alu_srl`, 11 `alu_sra`, 10 `alu_sra`. Also `load_regfile=1`, `load_cc=1`.
  - BR: `load_pc=1`, `pc_mux_sel=PC_OFFSET`, `offset_mux_sel=OFF9`. Execute gates the branch by nzp.
  - JMP: `load_pc=1`, `pc_mux_sel=PC_SR1`.
  - JSR: `load_pc=1`, `load_regfile=1`, `dest_mux_sel=1` (R7), `wb_mux_sel=WB_PC`. `pc_mux_sel` is PC_OFFSET with OFF11 when `ir[11]=1`, otherwise PC_SR1.
  - LDR/LDB: `read_memory=1`, `load_regfile=1`, `load_cc=1`, `wb_mux_sel=WB_MEM`, `offset_mux_sel=OFF6`.
  - STR/STB: `write_memory=1`, `offset_mux_sel=OFF6`, `instrsr1_mux_sel=1` (SR from `ir[11:9]`).
  - LEA: `load_regfile=1`, `load_cc=1`, `wb_mux_sel=WB_ADDR`, `offset_mux_sel=OFF9`.
  - TRAP: `read_memory=1`, `address_mux_sel=1` (trapvect), `load_pc=1`, `pc_mux_sel=PC_MEM`, `load_regfile=1`, `dest_mux_sel=1`, `wb_mux_sel=WB_PC`.
  - RTI and undefined opcodes: NOP (all loads/mem 0, `aluop=alu_pass`).
- LDI/STI phase 1: `read_memory=1`, `offset_mux_sel=OFF6`, `wb_mux_sel=WB_MEM`, `ex_indirect=0`. No reg/cc/pc write.
- Phase 2: `address_mux_sel=0`, `ex_indirect=1`. Execute takes the phase-1 read data as the address.
  - LDI: `read_memory=1`, `load_regfile=1`, `load_cc=1`.
  - STI: `write_memory=1`, `instrsr1_mux_sel=1`.
- `ex_ctrl.opcode` and `ex_ctrl.ir` always carry the original instruction.

## Timing
- Latency: instruction accepted at edge N is on `ex_ctrl` after edge N, for one or more cycles until `ex_ready`.
- Throughput: one instruction per cycle; LDI/STI take two.
- Back-pressure: while `ex_valid & !ex_ready`, all outputs are held stable.
- Accept and consume in the same cycle: the new word replaces the old, and `ex_valid` stays 1.
- `flush` (priority over everything except reset):
  - Next edge: `ex_valid=0`, `ex_indirect=0`, state IDLE.
  - `if_ready=0` in the flush cycle.
- Flush in IND2 drops phase 2.
- Reset: `ex_valid=0`, `ex_indirect=0`, `ex_ctrl` all zero (`opcode=op_br`, `aluop=alu_add`), `ex_pc=0`, state IDLE.
- Reset mid-IND2 abandons phase 2.
- `if_ready` during reset is 0.

## Structure
- Add to `lc3b_types`:
  - mux-select constants PC_PLUS2=0, PC_OFFSET=1, PC_SR1=2, PC_MEM=3;
  - WB_ALU=0, WB_MEM=1, WB_PC=2, WB_ADDR=3;
  - OFF6=0, OFF9=1, OFF11=2;
  - enum `lc3b_decode_state`.
- Sub-module `lc3b_control_rom`: purely combinational opcode/ir to `lc3b_control`, with a phase input (0 normal, 1 ind-phase1, 2 ind-phase2).
- This module holds the FSM and the pipeline register.

## Test plan
- ADD `0x1283` (R1=R2+R3), `ex_ready=1` → next cycle `ex_valid=1`, `aluop=alu_add`, `load_regfile=1`, `load_cc=1`, `immsr2_mux_sel=0`.
- Stream of 3 ANDs with `ex_ready` low for 2 cycles → `ex_ctrl` is stable and `if_ready=0` while held; all 3 emerge in order with none dropped or duplicated.
- LDI `0xA245` → two outputs: phase 1 `read_memory=1`, `load_regfile=0`; then phase 2 `ex_indirect=1`, `load_regfile=1`, `if_ready=0` between them.
- STI `0xB245`, `flush` asserted while in IND2 → `ex_valid=0` next cycle, no phase-2 `write_memory`, state IDLE, next ADD accepted.
- `rst_n=0` during back-pressured JSR `0x4802` → all outputs at reset values after the edge, and `if_ready=1` the cycle after release.
- TRAP `0xF025` and RTI `0x8000` → TRAP: `pc_mux_sel=3`, `dest_mux_sel=1`, `read_memory=1`; RTI: all load/mem bits 0.
